// File: rtl/adder_pkg.sv
// Shared types and constants for the handshaked adder, its interface and bench.
package adder_pkg;

  localparam int ADD_WIDTH = 8;
  localparam int TXN_CNT_W = 16;

  typedef logic [ADD_WIDTH-1:0] operand_t;

  typedef struct packed {
    operand_t a;
    operand_t b;
    logic     cin;
  } req_t;

  typedef struct packed {
    operand_t sum;
    logic     cout;
  } rsp_t;

endpackage : adder_pkg

// File: rtl/adder_stage.sv
// Valid/ready register slice with a parameterised payload width.
// A beat is held (valid and data stable) until the downstream side accepts it.
module adder_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_r;
  logic [W-1:0] data_r;
  logic         load_s;

  // The slice can take a new beat when empty or when its current beat leaves now.
  assign in_ready  = !valid_r || out_ready;
  assign load_s    = in_valid && in_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Occupancy and payload register; data only changes on a load so idle X inputs never enter.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {W{1'b0}};
    end else if (load_s) begin
      valid_r <= 1'b1;
      data_r  <= in_data;
    end else if (out_ready) begin
      valid_r <= 1'b0;
      data_r  <= data_r;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

endmodule : adder_stage

// File: rtl/adder_resp.sv
// Two-stage pipelined adder responder with valid/ready channels on both sides.
// Stage 1 registers the low-half sum and its carry alongside the raw high halves;
// stage 2 adds the high halves with that carry and presents {cout, sum}.
module adder_resp
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int CNT_W = TXN_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [CNT_W-1:0] txn_count
);

  localparam int HALF = WIDTH / 2;
  // Stage 1 payload: {c1, lo, a_hi, b_hi}
  localparam int S1_W = 1 + 3 * HALF;
  // Stage 2 payload: {cout, hi, lo}
  localparam int S2_W = WIDTH + 1;

  // Half-width add keeping the carry as the top bit, so nothing is truncated.
  function automatic logic [HALF:0] half_add(
    input logic [HALF-1:0] x,
    input logic [HALF-1:0] y,
    input logic            c
  );
    half_add = {1'b0, x} + {1'b0, y} + {{HALF{1'b0}}, c};
  endfunction

  logic            s1_in_ready_s;
  logic            s1_valid_s;
  logic            s2_in_ready_s;
  logic [S1_W-1:0] s1_in_data_s;
  logic [S1_W-1:0] s1_data_s;
  logic [S2_W-1:0] s2_in_data_s;
  logic [S2_W-1:0] s2_data_s;
  logic [HALF:0]   lo_sum_s;
  logic [HALF:0]   hi_sum_s;
  logic            c1_s;
  logic [HALF-1:0] lo_s;
  logic [HALF-1:0] a_hi_s;
  logic [HALF-1:0] b_hi_s;
  logic            xfer_s;
  logic [CNT_W-1:0] txn_count_r;

  // Low half sum with carry-in, packed with the untouched high halves.
  assign lo_sum_s     = half_add(a[HALF-1:0], b[HALF-1:0], cin);
  assign s1_in_data_s = {lo_sum_s, a[WIDTH-1:HALF], b[WIDTH-1:HALF]};

  // The request side is never ready while reset is asserted.
  assign in_ready = !rst && s1_in_ready_s;

  adder_stage #(.W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (s1_in_ready_s),
    .in_data   (s1_in_data_s),
    .out_valid (s1_valid_s),
    .out_ready (s2_in_ready_s),
    .out_data  (s1_data_s)
  );

  // Unpack stage 1 and finish the add with the full low-half carry.
  assign c1_s         = s1_data_s[S1_W-1];
  assign lo_s         = s1_data_s[S1_W-2 -: HALF];
  assign a_hi_s       = s1_data_s[2*HALF-1 -: HALF];
  assign b_hi_s       = s1_data_s[HALF-1:0];
  assign hi_sum_s     = half_add(a_hi_s, b_hi_s, c1_s);
  assign s2_in_data_s = {hi_sum_s, lo_s};

  adder_stage #(.W(S2_W)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid_s),
    .in_ready  (s2_in_ready_s),
    .in_data   (s2_in_data_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data_s)
  );

  // Result fields come straight from the stage 2 register.
  assign sum  = s2_data_s[WIDTH-1:0];
  assign cout = s2_data_s[WIDTH];

  assign xfer_s    = out_valid && out_ready;
  assign txn_count = txn_count_r;

  // Wrapping count of completed output handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count_r <= {CNT_W{1'b0}};
    end else if (xfer_s) begin
      txn_count_r <= txn_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      txn_count_r <= txn_count_r;
    end
  end

endmodule : adder_resp

// File: tb/tb_adder_resp.sv
// Scoreboard bench for adder_resp: the driver pushes hand-computed {cout,sum}
// on each accept, and an independent monitor pops and compares on each transfer.
module tb_adder_resp;
  import adder_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  operand_t    a;
  operand_t    b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  operand_t    sum;
  logic        cout;
  logic [15:0] txn_count;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  logic [8:0] exp_q[$];
  int         xfer_cyc[$];
  logic       hold_r = 1'b0;
  logic [8:0] held_r = 9'h000;

  adder_resp dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .txn_count (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: stability while stalled, then pop-and-compare on every transfer.
  always @(negedge clk) begin
    if (hold_r) begin
      chk("hold_valid", 32'(out_valid), 32'(1));
      chk("hold_data", 32'({cout, sum}), 32'(held_r));
    end
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(out_valid), 32'(0));
      end else begin
        chk("result", 32'({cout, sum}), 32'(exp_q.pop_front()));
      end
      xfer_cyc.push_back(cyc);
    end
    hold_r <= !rst && out_valid && !out_ready;
    held_r <= {cout, sum};
  end

  task automatic send(input operand_t ta, input operand_t tb, input logic tc,
                      input logic [8:0] texp);
    bit done;
    done = 1'b0;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(texp);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'(in_ready), 32'(1));
  endtask

  // Single request into an empty pipe: result appears exactly two edges after accept.
  task automatic send_lat(input operand_t ta, input operand_t tb, input logic tc,
                          input logic [8:0] texp);
    send(ta, tb, tc, texp);
    chk("lat_edge1", 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    chk("lat_edge2", 32'(out_valid), 32'(1));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  operand_t   bp_a[6] = '{8'h10, 8'h40, 8'hC0, 8'h01, 8'h03, 8'h7F};
  operand_t   bp_b[6] = '{8'h20, 8'h50, 8'h50, 8'h01, 8'h03, 8'h01};
  logic       bp_c[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [8:0] bp_e[6] = '{9'h031, 9'h090, 9'h110, 9'h002, 9'h006, 9'h080};

  initial begin
    int idx;
    rst = 1'b1; in_valid = 1'b1; a = 8'h55; b = 8'hAA; cin = 1'b1; out_ready = 1'b1;

    // Reset held for three edges with a request pending.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_sum", 32'(sum), 32'(0));
      chk("rst_txn", 32'(txn_count), 32'(0));
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;

    // Carry propagation.
    send_lat(8'h0F, 8'h01, 1'b0, 9'h010);
    send_lat(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    // Overflow and wrap.
    send_lat(8'hFF, 8'h01, 1'b0, 9'h100);
    send_lat(8'h80, 8'h80, 1'b0, 9'h100);
    wait_drain();
    chk("txn_after_single", 32'(txn_count), 32'(4));

    // Streaming: four back-to-back requests.
    pulse_reset();
    xfer_cyc.delete();
    send(8'd1, 8'd2, 1'b0, 9'd3);
    send(8'd3, 8'd4, 1'b0, 9'd7);
    send(8'd5, 8'd6, 1'b0, 9'd11);
    send(8'd7, 8'd8, 1'b0, 9'd15);
    wait_drain();
    chk("stream_count", 32'(xfer_cyc.size()), 32'(4));
    if (xfer_cyc.size() == 4) begin
      for (int i = 0; i < 3; i++)
        chk("stream_consecutive", 32'(xfer_cyc[i+1] - xfer_cyc[i]), 32'(1));
    end
    chk("stream_txn", 32'(txn_count), 32'(4));

    // Backpressure: only two requests fit while the consumer stalls.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      a = bp_a[idx]; b = bp_b[idx]; cin = bp_c[idx]; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(bp_e[idx]);
        idx++;
      end
      @(posedge clk); #1;
    end
    chk("bp_accepts", 32'(idx), 32'(2));
    chk("bp_in_ready", 32'(in_ready), 32'(0));
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    chk("bp_txn", 32'(txn_count), 32'(6));

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    send(8'h01, 8'h01, 1'b0, 9'h002);
    send(8'h02, 8'h02, 1'b0, 9'h004);
    pulse_reset();
    chk("mid_out_valid", 32'(out_valid), 32'(0));
    chk("mid_txn", 32'(txn_count), 32'(0));
    out_ready = 1'b1;
    a = 'x; b = 'x; cin = 1'bx;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mid_no_stale", 32'(out_valid), 32'(0));
    end
    chk("x_idle_data", 32'({cout, sum}), 32'(0));
    send_lat(8'h05, 8'h03, 1'b0, 9'h008);
    wait_drain();
    chk("final_txn", 32'(txn_count), 32'(1));
    chk("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_adder_resp
